// File: rtl/uart_rx_gen.sv
// uart_rx_gen: oversampling UART receiver with a valid/ready output register.
// A 16x sample tick drives a 2-of-3 majority bit slicer and the frame FSM.
// Completed words go to a one-deep output register. Line breaks, stop-bit
// errors and dropped words are reported as one-clk pulses.
// Optional feature: define UART_RX_PARITY_EN to build the parity state and
// the parity_err register (PARITY_MODE: 0 none, 1 even, 2 odd). Without the
// macro, PARITY_MODE is ignored and parity_err is tied low.
module uart_rx_gen #(
    parameter int CLOCK_SPEED = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int CNTR_WIDTH  = 18,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det
);

    // Clks per sample tick, never below one.
    localparam int DIV_RAW = (CLOCK_SPEED / BAUD) / 16;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;

    // Frame FSM encoding.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    // Reject illegal configurations at elaboration.
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_gen: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_gen: STOP_BITS must be 1 or 2");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity_mode
        $error("uart_rx_gen: PARITY_MODE must be 0, 1 or 2");
    end

    logic                  rx_meta;
    logic                  rx_sync;
    logic [CNTR_WIDTH-1:0] cnt;
    logic                  tick;
    logic [3:0]            hist;
    logic [3:0]            phase;
    logic [2:0]            state;
    logic [3:0]            bit_idx;
    logic                  stop_idx;
    logic                  stop_low;
    logic                  stop_high;
    logic [DATA_BITS-1:0]  shreg;
`ifdef UART_RX_PARITY_EN
    logic                  par_bad;
`endif

    logic                  maj;
    logic                  bit_eval;
    logic                  last_stop;
    logic                  stop_any_low;
    logic                  stop_any_high;
    logic                  frame_end;
    logic                  deliver;
    logic                  frame_bad;
    logic                  brk;

    // Two-flop synchroniser on the raw serial line; idles high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Sample-tick timer: one tick every DIV clks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNTR_WIDTH'(DIV - 1));

    // Sample history, newest sample in bit 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist <= '1;
        end else if (tick) begin
            hist <= {hist[2:0], rx_sync};
        end
    end

    // Bit slicer and frame bookkeeping. The phase-9 sample is the one being
    // taken this tick, so the majority uses the live synchronised bit plus
    // the two most recent history entries (phases 7 and 8).
    always_comb begin
        maj           = (hist[1] & hist[0]) | (hist[1] & rx_sync) | (hist[0] & rx_sync);
        bit_eval      = tick && (phase == 4'd9);
        last_stop     = (stop_idx == 1'(STOP_BITS - 1));
        stop_any_low  = stop_low | ~maj;
        stop_any_high = stop_high | maj;
        frame_end     = bit_eval && (state == S_STOP) && last_stop;
        deliver       = frame_end && !stop_any_low;
        frame_bad     = frame_end && stop_any_low && ((shreg != '0) || stop_any_high);
        brk           = frame_end && stop_any_low && (shreg == '0) && !stop_any_high;
    end

    // Frame FSM; advances only on sample ticks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            phase     <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            stop_low  <= 1'b0;
            stop_high <= 1'b0;
            shreg     <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
`endif
        end else if (tick) begin
            phase <= phase + 4'd1;
            case (state)
                S_IDLE: begin
                    if (hist == 4'b1110) begin
                        state     <= S_START;
                        phase     <= '0;
                        bit_idx   <= '0;
                        stop_idx  <= 1'b0;
                        stop_low  <= 1'b0;
                        stop_high <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        par_bad   <= 1'b0;
`endif
                    end
                end
                S_START: begin
                    if (bit_eval) begin
                        state <= maj ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_eval) begin
                        shreg <= {maj, shreg[DATA_BITS-1:1]};
                        if (bit_idx == 4'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
`else
                            state   <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (bit_eval) begin
                        par_bad <= maj ^ (^shreg) ^ (PARITY_MODE == 2);
                        state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_eval) begin
                        if (last_stop) begin
                            state <= brk ? S_BREAK : S_IDLE;
                        end else begin
                            stop_idx  <= 1'b1;
                            stop_low  <= stop_any_low;
                            stop_high <= stop_any_high;
                        end
                    end
                end
                S_BREAK: begin
                    if (bit_eval && maj) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output register with valid/ready handshake and overrun detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= deliver && valid && !ready;
            if (deliver && (!valid || ready)) begin
                data  <= shreg;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity flag travels with the held word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (deliver && (!valid || ready)) begin
            parity_err <= par_bad;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // Line-error pulses, one clk each.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            break_det <= 1'b0;
        end else begin
            frame_err <= frame_bad;
            break_det <= brk;
        end
    end

endmodule

// File: tb/tb_uart_rx_gen.sv
// tb_uart_rx_gen: directed bench for uart_rx_gen at 16 clks per bit
// (one sample tick per clk). Frame layout follows UART_RX_PARITY_EN.
module tb_uart_rx_gen;

    localparam int BIT_CLKS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
    localparam logic EXP_PE_BAD = 1'b1;
`else
    localparam int PAR_BITS = 0;
    localparam logic EXP_PE_BAD = 1'b0;
`endif
    // Clk (counted in negedges from the start-bit negedge) whose rising edge
    // follows the stop-bit evaluation: start detect at edge 3, phase 9 ten
    // edges later, 16 edges per bit.
    localparam int STOP_EVAL = 13 + BIT_CLKS * (9 + PAR_BITS);

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       break_det;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int bk_cnt = 0;
    int fe_base, ov_base, bk_base;

    uart_rx_gen #(
        .CLOCK_SPEED(1_843_200),
        .BAUD(115_200),
        .CNTR_WIDTH(18),
        .DATA_BITS(8),
        .STOP_BITS(1),
        .PARITY_MODE(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx(rx),
        .data(data),
        .valid(valid),
        .ready(ready),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .overrun(overrun),
        .break_det(break_det)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun)   ov_cnt++;
        if (break_det) bk_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        fe_base = fe_cnt;
        ov_base = ov_cnt;
        bk_base = bk_cnt;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Start bit, 8 data bits LSB first, optional even-parity bit, one stop bit.
    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_b);
        logic [11:0] bits;
        int          nbits;
        logic        par_bit;
        par_bit = (^d) ^ bad_par;
`ifdef UART_RX_PARITY_EN
        bits  = {1'b1, stop_b, par_bit, d, 1'b0};
        nbits = 11;
`else
        bits  = {1'b1, par_bit, stop_b, d, 1'b0};
        nbits = 10;
`endif
        @(negedge clk);
        for (int i = 0; i < nbits; i++) send_bit(bits[i]);
        rx = 1'b1;
    endtask

    task automatic drain();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        rx    = 1'b1;
        ready = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_pulses", {frame_err, overrun, break_det}, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Plain frame and handshake.
        send_frame(8'hA5, 1'b0, 1'b1);
        check("a5_valid", valid, 1);
        check("a5_data", data, 8'hA5);
        check("a5_parity_err", parity_err, 0);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("a5_valid_cleared", valid, 0);
        check("a5_data_hold", data, 8'hA5);

        // Parity: 0x07 has odd weight, so even parity expects a 1.
        send_frame(8'h07, 1'b1, 1'b1);
        check("p0_data", data, 8'h07);
        check("p0_parity_err", parity_err, EXP_PE_BAD);
        drain();
        send_frame(8'h07, 1'b0, 1'b1);
        check("p1_data", data, 8'h07);
        check("p1_parity_err", parity_err, 0);
        drain();

        // Four-clk low glitch on an idle line.
        snap();
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_valid", valid, 0);
        check("glitch_pulses", (fe_cnt - fe_base) + (ov_cnt - ov_base) + (bk_cnt - bk_base), 0);

        // Bad stop bit.
        snap();
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("fe_pulse", fe_cnt - fe_base, 1);
        check("fe_valid", valid, 0);
        check("fe_no_break", bk_cnt - bk_base, 0);

        // Line held low for 20 bit times.
        snap();
        @(negedge clk);
        rx = 1'b0;
        repeat (20 * BIT_CLKS) @(negedge clk);
        check("brk_pulse_low", bk_cnt - bk_base, 1);
        check("brk_no_fe", fe_cnt - fe_base, 0);
        rx = 1'b1;
        repeat (48) @(negedge clk);
        check("brk_pulse_total", bk_cnt - bk_base, 1);
        check("brk_valid", valid, 0);
        send_frame(8'h5A, 1'b0, 1'b1);
        check("brk_recover_data", data, 8'h5A);
        check("brk_recover_valid", valid, 1);
        drain();

        // Overrun with ready low.
        snap();
        send_frame(8'h11, 1'b0, 1'b1);
        check("ov_first_data", data, 8'h11);
        send_frame(8'h22, 1'b0, 1'b1);
        check("ov_pulse", ov_cnt - ov_base, 1);
        check("ov_data_kept", data, 8'h11);
        check("ov_valid", valid, 1);

        // Transfer on the same clk as a delivery.
        snap();
        fork
            send_frame(8'h33, 1'b0, 1'b1);
            begin
                @(negedge clk);
                repeat (STOP_EVAL) @(negedge clk);
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
            end
        join
        check("sim_data", data, 8'h33);
        check("sim_valid", valid, 1);
        check("sim_no_overrun", ov_cnt - ov_base, 0);

        // Reset during bit 3 of 0x55 with 0x33 still held.
        snap();
        @(negedge clk);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        rx    = 1'b1;
        repeat (60) @(negedge clk);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_pulses", (fe_cnt - fe_base) + (ov_cnt - ov_base) + (bk_cnt - bk_base), 0);
        send_frame(8'h66, 1'b0, 1'b1);
        check("after_rst_data", data, 8'h66);
        check("after_rst_valid", valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
